// File: rtl/imm_encoder.sv
// Two-stage instruction-word encoder: packs opcode, register fields, funct3 and an
// immediate into an I/S/B word, flags out-of-range immediates and counts them.
module imm_encoder #(
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [6:0]           in_opcode,
    input  logic [2:0]           in_funct3,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [31:0]          in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_inst,
    output logic [1:0]           out_fmt,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int unsigned OPC_W    = 7;
    localparam int unsigned F3_W     = 3;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned IMM_W    = 32;
    localparam int unsigned IMM_LO_W = 12;
    localparam int unsigned INST_W   = 32;
    localparam int unsigned FMT_W    = 2;

    localparam logic [OPC_W-1:0] OPC_B = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_S = 7'b0100011;
    localparam logic [FMT_W-1:0] FMT_I = 2'd0;
    localparam logic [FMT_W-1:0] FMT_S = 2'd1;
    localparam logic [FMT_W-1:0] FMT_B = 2'd2;

    typedef struct packed {
        logic [OPC_W-1:0]    opcode;
        logic [F3_W-1:0]     funct3;
        logic [REG_W-1:0]    rd;
        logic [REG_W-1:0]    rs1;
        logic [REG_W-1:0]    rs2;
        logic [IMM_LO_W-1:0] imm;
        logic [FMT_W-1:0]    fmt;
        logic                err;
    } s1_t;

    s1_t                  s1_d, s1_q;
    logic                 s1_valid_q;
    logic                 out_valid_q;
    logic [INST_W-1:0]    inst_d, inst_q;
    logic [FMT_W-1:0]     fmt_q;
    logic                 err_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic                 s2_adv;
    logic                 s1_adv;

    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    // Request capture: format classification and range check happen before S1.
    always_comb begin
        s1_d        = '0;
        s1_d.opcode = in_opcode;
        s1_d.funct3 = in_funct3;
        s1_d.rd     = in_rd;
        s1_d.rs1    = in_rs1;
        s1_d.rs2    = in_rs2;
        s1_d.imm    = in_imm[IMM_LO_W-1:0];
        case (in_opcode)
            OPC_B:   s1_d.fmt = FMT_B;
            OPC_S:   s1_d.fmt = FMT_S;
            default: s1_d.fmt = FMT_I;
        endcase
        s1_d.err = in_imm[IMM_W-1:IMM_LO_W] != {(IMM_W-IMM_LO_W){in_imm[IMM_LO_W-1]}};
    end

    // Word assembly from the S1 snapshot; B uses the decode side's halfword-unit mapping.
    always_comb begin
        inst_d        = '0;
        inst_d[6:0]   = s1_q.opcode;
        inst_d[14:12] = s1_q.funct3;
        inst_d[19:15] = s1_q.rs1;
        case (s1_q.fmt)
            FMT_S: begin
                inst_d[24:20] = s1_q.rs2;
                inst_d[31:25] = s1_q.imm[11:5];
                inst_d[11:7]  = s1_q.imm[4:0];
            end
            FMT_B: begin
                inst_d[24:20] = s1_q.rs2;
                inst_d[31]    = s1_q.imm[11];
                inst_d[7]     = s1_q.imm[10];
                inst_d[30:25] = s1_q.imm[9:4];
                inst_d[11:8]  = s1_q.imm[3:0];
            end
            default: begin
                inst_d[31:20] = s1_q.imm;
                inst_d[11:7]  = s1_q.rd;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            inst_q      <= '0;
            fmt_q       <= '0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_q <= s1_d;
                end
            end
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    inst_q <= inst_d;
                    fmt_q  <= s1_q.fmt;
                    err_q  <= s1_q.err;
                end
            end
            // Count only words that actually leave, saturating at all-ones.
            if (out_valid_q && out_ready && err_q && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_inst  = inst_q;
    assign out_fmt   = fmt_q;
    assign out_err   = err_q;
    assign err_count = err_cnt_q;

endmodule
